// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional build macro RV32I_CTRL_PERF_EN adds cycle_cnt and instret_cnt performance counters.
module rv32i_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned RESET_PC_SEL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        sys_bit,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        halted,
    output logic [1:0]  trap,
    output logic [2:0]  state_o
`ifdef RV32I_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t            state, state_next;
    logic [1:0]        trap_q, trap_next;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;

    logic is_rtype, is_itype, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_sys;
    logic legal;
    logic unused_sys;

    // ECALL and EBREAK both retire into HALT, so ir[20] carries no control meaning here.
    assign unused_sys = sys_bit;

    assign is_rtype  = (opcode == 7'h33);
    assign is_itype  = (opcode == 7'h13);
    assign is_load   = (opcode == 7'h03);
    assign is_store  = (opcode == 7'h23);
    assign is_branch = (opcode == 7'h63);
    assign is_jal    = (opcode == 7'h6F);
    assign is_jalr   = (opcode == 7'h67);
    assign is_lui    = (opcode == 7'h37);
    assign is_auipc  = (opcode == 7'h17);
    assign is_sys    = (opcode == 7'h73);

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        else if (is_store)
            legal = (funct3 <= 3'd2);
        else if (is_branch)
            legal = !(funct3 == 3'd2 || funct3 == 3'd3);
        else
            legal = is_rtype | is_itype | is_jal | is_jalr | is_lui | is_auipc | is_sys;
    end

    // Count value equal to the limit marks the expiry cycle; an ack in that cycle still completes.
    assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            trap_q <= 2'd0;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            trap_q <= trap_next;
            if (state_next != state)
                to_cnt <= '0;
            else if (mem_req && !mem_ack)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        trap_next  = trap_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        alu_a_pc   = 1'b0;
        alu_b_imm  = 1'b0;
        halted     = 1'b0;
        trap       = 2'd0;
        case (state)
            S_IDLE: begin
                pc_src = 2'(RESET_PC_SEL);
                if (start) begin
                    pc_we      = 1'b1;
                    pc_src     = 2'd3;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (to_hit && !mem_ack) begin
                    state_next = S_TRAP;
                    trap_next  = 2'd2;
                end else begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    if (mem_ack) begin
                        ir_we      = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    trap_next  = 2'd1;
                end
            end
            S_EXEC: begin
                alu_a_pc  = is_auipc | is_jal | is_branch;
                alu_b_imm = is_itype | is_load | is_store | is_jalr | is_auipc;
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_branch) begin
                    pc_we      = 1'b1;
                    pc_src     = {1'b0, branch_taken};
                    state_next = S_FETCH;
                end else if (is_sys) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (to_hit && !mem_ack) begin
                    state_next = S_TRAP;
                    trap_next  = 2'd2;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (mem_ack) begin
                        if (is_store) begin
                            pc_we      = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                state_next = S_FETCH;
                if (is_load)
                    wb_sel = 2'd1;
                else if (is_jal || is_jalr)
                    wb_sel = 2'd2;
                else if (is_lui)
                    wb_sel = 2'd3;
                if (is_jal)
                    pc_src = 2'd1;
                else if (is_jalr)
                    pc_src = 2'd2;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_TRAP: begin
                trap = trap_q;
            end
        endcase
    end

    assign state_o = state;

`ifdef RV32I_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != S_IDLE && state != S_HALT && state != S_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if ((pc_we && state != S_IDLE) || (state != S_HALT && state_next == S_HALT))
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: per-instruction cycle plans built from the instruction rules.
`timescale 1ns/1ps
module tb_rv32i_multicycle_ctrl;

    localparam int         TMO = 4;
    localparam logic [1:0] RPC = 2'd2;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6, TRAP = 3'd7;

    logic clk, rst, start, sys_bit, branch_taken, mem_ack;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic mem_req, mem_we, mem_ifetch, ir_we, pc_we, rf_we, alu_a_pc, alu_b_imm, halted;
    logic [1:0] pc_src, wb_sel, trap;
    logic [2:0] state_o;
`ifdef RV32I_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .RESET_PC_SEL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
        .sys_bit(sys_bit), .branch_taken(branch_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ifetch(mem_ifetch), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .halted(halted), .trap(trap),
        .state_o(state_o)
`ifdef RV32I_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, we, ifetch, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       apc, bimm, halted;
        logic [1:0] trap;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic        rstn, start, ack, sysb, taken;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] cyc, ret;
    } rec_t;

    rec_t        q[$];
    rec_t        exp_r;
    bit          exp_vld;
    outs_t       act;
    int          n_tests, n_fail;
    logic [31:0] m_cyc, m_ret;
    logic [6:0]  cur_opc;
    logic [2:0]  cur_f3;
    logic        cur_sys, cur_taken;

    function automatic outs_t mk(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("st=%0d req=%b we=%b ifetch=%b ir_we=%b pc_we=%b pc_src=%0d rf_we=%b wb_sel=%0d a_pc=%b b_imm=%b halted=%b trap=%0d",
                         o.st, o.req, o.we, o.ifetch, o.irwe, o.pcwe, o.pcsrc, o.rfwe, o.wbsel,
                         o.apc, o.bimm, o.halted, o.trap);
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73: return 1'b1;
            7'h03: return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            7'h23: return f3 <= 3'd2;
            7'h63: return !(f3 == 3'd2 || f3 == 3'd3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One planned cycle: the inputs to drive and the outputs the rules demand for it.
    task automatic push(input outs_t o, input logic ack, input logic rstn, input logic strt,
                        input logic ret_extra);
        rec_t r;
        r.o = o; r.ack = ack; r.rstn = rstn; r.start = strt;
        r.opc = cur_opc; r.f3 = cur_f3; r.sysb = cur_sys; r.taken = cur_taken;
        r.cyc = m_cyc; r.ret = m_ret;
        q.push_back(r);
        if (!rstn) begin
            m_cyc = 0;
            m_ret = 0;
        end else begin
            if (!(o.st == IDLE || o.st == HALT || o.st == TRAP)) m_cyc = m_cyc + 1;
            if ((o.pcwe && o.st != IDLE) || ret_extra) m_ret = m_ret + 1;
        end
    endtask

    task automatic start_prog(input int idle_cycles);
        outs_t o;
        o = mk(IDLE);
        o.pcsrc = RPC;
        for (int i = 0; i < idle_cycles; i++) push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        o.pcwe = 1'b1;
        o.pcsrc = 2'd3;
        push(o, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Ack arrives on request cycle d (0 = first); no ack by cycle TMO means a bus timeout.
    task automatic mem_phase(input logic [2:0] st, input logic store, input int d, output bit ok);
        outs_t o;
        ok = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            o = mk(st);
            if (i == d) begin
                o.req = 1'b1; o.we = store; o.ifetch = (st == FETCH);
                o.irwe = (st == FETCH); o.pcwe = store;
                push(o, 1'b1, 1'b1, 1'b0, 1'b0);
                ok = 1'b1;
                return;
            end
            if (i == TMO) begin
                push(o, 1'b0, 1'b1, 1'b0, 1'b0);
                return;
            end
            o.req = 1'b1; o.we = store; o.ifetch = (st == FETCH);
            push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic park(input logic [2:0] st, input logic [1:0] code);
        outs_t o;
        int n;
        o = mk(st);
        o.halted = (st == HALT);
        o.trap = code;
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        push(o, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fetch_reset();
        outs_t o;
        o = mk(FETCH);
        o.req = 1'b1;
        o.ifetch = 1'b1;
        push(o, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_instr(input logic [31:0] w, input logic tk, input int fd, input int md,
                            output bit stopped);
        outs_t o;
        bit ok;
        logic [6:0] op;
        op = w[6:0];
        cur_opc = op; cur_f3 = w[14:12]; cur_sys = w[20]; cur_taken = tk;
        stopped = 1'b1;
        mem_phase(FETCH, 1'b0, fd, ok);
        if (!ok) begin park(TRAP, 2'd2); return; end
        push(mk(DECODE), 1'b0, 1'b1, 1'b0, 1'b0);
        if (!legal(op, cur_f3)) begin park(TRAP, 2'd1); return; end
        o = mk(EXEC);
        o.apc  = (op == 7'h17 || op == 7'h6F || op == 7'h63);
        o.bimm = (op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h67 || op == 7'h17);
        case (op)
            7'h03, 7'h23: begin
                push(o, 1'b0, 1'b1, 1'b0, 1'b0);
                mem_phase(MEM, op == 7'h23, md, ok);
                if (!ok) begin park(TRAP, 2'd2); return; end
                if (op == 7'h03) begin
                    o = mk(WB); o.rfwe = 1'b1; o.pcwe = 1'b1; o.wbsel = 2'd1;
                    push(o, 1'b0, 1'b1, 1'b0, 1'b0);
                end
            end
            7'h63: begin
                o.pcwe = 1'b1;
                o.pcsrc = tk ? 2'd1 : 2'd0;
                push(o, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            7'h73: begin
                push(o, 1'b0, 1'b1, 1'b0, 1'b1);
                park(HALT, 2'd0);
                return;
            end
            default: begin
                push(o, 1'b0, 1'b1, 1'b0, 1'b0);
                o = mk(WB); o.rfwe = 1'b1; o.pcwe = 1'b1;
                o.wbsel = (op == 7'h6F || op == 7'h67) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
                o.pcsrc = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
                push(o, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        endcase
        stopped = 1'b0;
    endtask

    task automatic play();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            rst = r.rstn; start = r.start; mem_ack = r.ack; opcode = r.opc;
            funct3 = r.f3; sys_bit = r.sysb; branch_taken = r.taken;
            exp_r = r;
            exp_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_vld = 1'b0;
    endtask

    function automatic int cnt_recs(input logic [2:0] st, input bit need_req);
        int n;
        n = 0;
        foreach (q[i]) if (q[i].o.st == st && (!need_req || q[i].o.req)) n++;
        return n;
    endfunction

    function automatic int first_rst();
        foreach (q[i]) if (!q[i].rstn) return i;
        return 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tbl [12];
        logic [31:0] w;
        tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h0B};
        w = $urandom;
        w[6:0] = tbl[$urandom_range(0, 11)];
        return w;
    endfunction

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 15);
        return (r < 13) ? (r % 5) : 5;
    endfunction

    always @(negedge clk) begin
        if (exp_vld) begin
            act = {mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_src, rf_we, wb_sel,
                   alu_a_pc, alu_b_imm, halted, trap, state_o};
            n_tests++;
            if (act !== exp_r.o) begin
                n_fail++;
                $display("FAIL outputs @%0t: got {%s} want {%s}", $time, fmt(act), fmt(exp_r.o));
            end
`ifdef RV32I_CTRL_PERF_EN
            n_tests++;
            if (cycle_cnt !== exp_r.cyc || instret_cnt !== exp_r.ret) begin
                n_fail++;
                $display("FAIL perf_counters @%0t: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         $time, cycle_cnt, instret_cnt, exp_r.cyc, exp_r.ret);
            end
`endif
        end
    end

    initial begin
        bit stopped;
        int a, b, c;
        outs_t o;
        bit ok;
        n_tests = 0; n_fail = 0; exp_vld = 1'b0;
        m_cyc = 0; m_ret = 0;
        cur_opc = 7'h13; cur_f3 = 3'd0; cur_sys = 1'b0; cur_taken = 1'b0;
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0; opcode = 7'h13; funct3 = 3'd0;
        sys_bit = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_idle", {23'd0, state_o, pc_src, mem_req, pc_we, trap},
            {23'd0, 3'd0, 2'd2, 1'b0, 1'b0, 2'd0});

        // ADDI x1,x0,5 twice, ack one cycle after each request
        start_prog(1);
        do_instr(32'h00500093, 1'b0, 1, 0, stopped);
        do_instr(32'h00500093, 1'b0, 1, 0, stopped);
        fetch_reset();
        a = -1; b = -1;
        foreach (q[i]) if (a < 0 && q[i].o.req) a = i;
        for (int j = a + 1; j < q.size(); j++)
            if (b < 0 && q[j].o.req && !q[j - 1].o.req) b = j;
        chk("addi_req_to_req", b - a, 5);
        chk("addi_states", {q[a].o.st, q[a + 1].o.st, q[a + 2].o.st, q[a + 3].o.st, q[a + 4].o.st, q[a + 5].o.st},
            {3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1});
        chk("addi_wb", {q[a + 4].o.rfwe, q[a + 4].o.wbsel, q[a + 4].o.pcsrc}, 5'b1_00_00);
        play();

        // LW, memory ack delayed three cycles
        start_prog(0);
        do_instr(32'h0000A103, 1'b0, 1, 3, stopped);
        fetch_reset();
        c = 0;
        foreach (q[i]) if (q[i].o.st == MEM && q[i].o.req && !q[i].o.we) c++;
        chk("lw_mem_req_cycles", c, 4);
        foreach (q[i]) if (q[i].o.st == WB) chk("lw_wb_sel", q[i].o.wbsel, 1);
        play();

        // BEQ taken then not taken
        start_prog(0);
        do_instr(32'h00000063, 1'b1, 0, 0, stopped);
        do_instr(32'h00000063, 1'b0, 0, 0, stopped);
        fetch_reset();
        a = -1; b = -1; c = 0;
        foreach (q[i]) begin
            if (q[i].o.st == EXEC && q[i].o.pcwe) begin
                if (a < 0) a = q[i].o.pcsrc; else b = q[i].o.pcsrc;
            end
            if (q[i].o.rfwe) c++;
        end
        chk("beq_pc_src", {a[1:0], b[1:0]}, 4'b0100);
        chk("beq_no_rf_we", c, 0);
        play();

        // Illegal opcode, then load with funct3=3
        start_prog(0);
        do_instr(32'h0000007F, 1'b0, 0, 0, stopped);
        chk("illegal_op_trap", q[first_rst()].o.trap, 1);
        play();
        start_prog(0);
        do_instr(32'h00003003, 1'b0, 0, 0, stopped);
        chk("illegal_f3_trap", q[first_rst()].o.trap, 1);
        play();

        // Fetch bus timeout, then ack on the 4th and on the expiry cycle
        start_prog(0);
        do_instr(32'h00500093, 1'b0, 5, 0, stopped);
        chk("timeout_req_cycles", cnt_recs(FETCH, 1'b1), 4);
        chk("timeout_trap", q[first_rst()].o.trap, 2);
        play();
        start_prog(0);
        do_instr(32'h00500093, 1'b0, 3, 0, stopped);
        fetch_reset();
        chk("ack4_decode", cnt_recs(DECODE, 1'b0), 1);
        play();
        start_prog(0);
        do_instr(32'h00500093, 1'b0, 4, 0, stopped);
        fetch_reset();
        chk("ack_at_expiry_decode", cnt_recs(DECODE, 1'b0), 1);
        play();

        // EBREAK, reset mid-HALT
        start_prog(0);
        do_instr(32'h00100073, 1'b0, 0, 0, stopped);
        a = -1;
        foreach (q[i]) if (a < 0 && q[i].o.st == HALT) a = i;
        chk("ebreak_halted", q[a].o.halted, 1);
        chk("ebreak_instret", q[a].ret, 1);
        play();

        // Reset during a load's memory wait
        start_prog(0);
        cur_opc = 7'h03; cur_f3 = 3'd2; cur_sys = 1'b0; cur_taken = 1'b0;
        mem_phase(FETCH, 1'b0, 0, ok);
        push(mk(DECODE), 1'b0, 1'b1, 1'b0, 1'b0);
        o = mk(EXEC); o.bimm = 1'b1;
        push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        o = mk(MEM); o.req = 1'b1;
        push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        push(o, 1'b0, 1'b0, 1'b0, 1'b0);
        o = mk(IDLE); o.pcsrc = RPC;
        push(o, 1'b0, 1'b1, 1'b0, 1'b0);
        play();

        // Random instruction streams
        for (int p = 0; p < 40; p++) begin
            start_prog($urandom_range(0, 2));
            stopped = 1'b0;
            for (int k = 0; k < 6 && !stopped; k++)
                do_instr(rand_instr(), 1'($urandom_range(0, 1)), rand_delay(), rand_delay(), stopped);
            if (!stopped) fetch_reset();
            play();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the shared ALU, register file and a single request/acknowledge memory port. It classifies the instruction from the opcode and funct3 fields held in the instruction register. It then produces all datapath enables and selects, and flags halt, illegal-instruction and bus-timeout conditions.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for mem_ack before bus-error trap; 0 disables the timeout.
RESET_PC_SEL, 0, value of pc_src driven in IDLE, so the PC mux loads the reset vector on the first pc_we.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-low reset
start  in  1  leave IDLE and begin fetching
opcode  in  7  ir[6:0] from instruction register
funct3  in  3  ir[14:12]
sys_bit  in  1  ir[20]; 0=ECALL, 1=EBREAK
branch_taken  in  1  ALU compare result, valid in EXECUTE
mem_ack  in  1  memory transfer complete, single-cycle pulse
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=store request
mem_ifetch  out  1  1=request is an instruction fetch
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  2  0=pc+4, 1=pc+imm (branch/jal), 2=alu result (jalr), 3=reset vector
rf_we  out  1  register file write
wb_sel  out  2  0=alu, 1=load data, 2=pc+4, 3=imm (lui)
alu_a_pc  out  1  ALU operand A = PC (auipc/jal/branch target)
alu_b_imm  out  1  ALU operand B = immediate
halted  out  1  ECALL/EBREAK retired; core stopped
trap  out  2  0=none, 1=illegal opcode/funct3, 2=bus timeout
state_o  out  3  current state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7. State register is synchronous; outputs decode combinationally from state and inputs.
- Reset (rst=0 at a clk edge) returns to IDLE from any state, including mid-request. In IDLE all outputs are 0, except pc_src=RESET_PC_SEL and trap=0.
- IDLE: when start=1, pulse pc_we with pc_src=3 and go to FETCH.
- FETCH: mem_req=1, mem_ifetch=1. When mem_ack=1, drive ir_we=1 in the same cycle and go to DECODE. Otherwise stay.
- DECODE: one cycle. Legal opcodes are 33,13,03,23,63,6F,67,37,17,73 (hex). An illegal opcode, a load funct3 in {3,6,7}, a store funct3 >2, or a branch funct3 in {2,3} goes to TRAP with trap=1. All other cases go to EXEC.
- EXEC, per class:
  - R-type/I-type ALU, LUI, AUIPC, JAL, JALR: go to WB.
  - Load/store: alu_b_imm=1, go to MEM.
  - Branch: pc_we=1; pc_src=1 if branch_taken else 0; go to FETCH.
  - System: go to HALT.
  - alu_a_pc=1 for AUIPC, JAL and branch; alu_b_imm=1 for I-type, load, store, JALR and AUIPC.
- MEM: mem_req=1, mem_we=1 for store. On mem_ack: a load goes to WB; a store pulses pc_we (pc_src=0) and goes to FETCH.
- WB: rf_we=1 and pc_we=1, one cycle, then FETCH.
  - wb_sel: load=1, JAL/JALR=2, LUI=3, else 0.
  - pc_src: JAL=1, JALR=2, else 0.
- Timeout: a counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 without ack. If it reaches MEM_TIMEOUT, go to TRAP with trap=2 and drop mem_req that cycle. An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: the transfer completes normally.
- HALT: halted=1, all enables 0. Exit only by reset.
- TRAP: trap holds its code, all enables 0. Exit only by reset.
- mem_req never deasserts before ack or timeout. mem_we and mem_ifetch stay stable while mem_req=1.
- Latency: ALU op = 4 cycles plus fetch wait; load = 5 cycles plus two waits; store/branch = 4/3 cycles plus waits.

Optional Feature:
Macro RV32I_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every cycle outside IDLE/HALT/TRAP.
  - instret_cnt increments on each pc_we outside IDLE, plus once on entry to HALT.
  - Both wrap at 2^32.
- Not defined: ports and counters absent, and FSM behaviour is identical.

Test Plan:
- ADDI x1,x0,5 (0x00500093), ack 1 cycle after each req, start pulse:
  - FETCH→DECODE→EXEC→WB→FETCH.
  - rf_we=1, wb_sel=0, pc_src=0 in WB.
  - 5 cycles from first mem_req to next mem_req.
- LW (0x0000A103), ack delayed 3 cycles:
  - MEM holds mem_req=1, mem_we=0 for 4 cycles.
  - WB has wb_sel=1.
- BEQ with branch_taken=1, then with 0:
  - EXEC gives pc_we=1 with pc_src=1, then pc_src=0.
  - rf_we never asserted.
- Opcode 0x7F, and load funct3=3:
  - TRAP with trap=1.
  - Subsequent mem_req=0 and pc_we=0 until rst=0.
- MEM_TIMEOUT=4, no ack in FETCH:
  - trap=2 after 4 req cycles.
  - Repeat with ack on the 4th cycle: no trap, and DECODE is entered.
- EBREAK (0x00100073):
  - halted=1 from HALT onward.
  - Assert rst=0 mid-HALT, and separately mid-MEM wait: next state IDLE with all outputs cleared.
  - With RV32I_CTRL_PERF_EN, instret_cnt=1 after the EBREAK.
